// File: rtl/conv_pkg.sv
// Shared widths and constants for the convolution output path.
package conv_pkg;

    localparam int AXIS_DATA_W          = 32;
    localparam int PIX_W                = 8;
    localparam int KEEP_W               = AXIS_DATA_W / PIX_W;
    localparam int PACK_W               = AXIS_DATA_W - PIX_W;
    localparam int DEFAULT_FRAME_PIXELS = 260100;
    localparam int DEFAULT_CNT_W        = 20;

    // Indexed by number of valid bytes in the word (0..4).
    localparam logic [KEEP_W:0][KEEP_W-1:0] KEEP_FROM_COUNT = {
        4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register; accepts a new word whenever
// it is empty or its current word is being taken in the same cycle.
module axis_out_reg
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [AXIS_DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0]      load_keep,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   out_valid,
    output logic [AXIS_DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0]      out_keep,
    output logic                   out_last,
    input  logic                   out_ready
);

    logic                   valid_reg;
    logic [AXIS_DATA_W-1:0] data_reg;
    logic [KEEP_W-1:0]      keep_reg;
    logic                   last_reg;

    assign load_ready = !valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            keep_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            keep_reg  <= load_keep;
            last_reg  <= load_last;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_keep  = keep_reg;
    assign out_last  = last_reg;

endmodule

// File: rtl/conv_out_packer.sv
// Packs the 8-bit convolved pixel stream into little-endian 32-bit
// AXI-Stream words with TKEEP/TLAST and a frame-done pulse.
module conv_out_packer
    import conv_pkg::*;
#(
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset_n,
    input  logic                   i_data_valid,
    input  logic [PIX_W-1:0]       i_data,
    output logic                   o_data_ready,
    output logic                   o_word_valid,
    output logic [AXIS_DATA_W-1:0] o_word_data,
    output logic [KEEP_W-1:0]      o_word_keep,
    output logic                   o_word_last,
    input  logic                   i_word_ready,
    output logic                   o_frame_done
);

    logic [1:0]             lane_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [PACK_W-1:0]      pack_reg;
    logic                   done_reg;
    logic                   accept;
    logic                   frame_end;
    logic                   complete;
    logic [AXIS_DATA_W-1:0] word_next;
    logic [KEEP_W-1:0]      keep_next;

    assign accept    = i_data_valid && o_data_ready;
    assign frame_end = (cnt_reg == CNT_W'(FRAME_PIXELS - 1));
    assign complete  = accept && ((lane_reg == 2'd3) || frame_end);
    assign keep_next = KEEP_FROM_COUNT[3'(lane_reg) + 3'd1];

    // Current pixel merged into its lane; lanes above it are still zero.
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_byte
        if (gi < KEEP_W - 1) begin : g_packed
            assign word_next[gi*PIX_W +: PIX_W] =
                (lane_reg == 2'(gi)) ? i_data : pack_reg[gi*PIX_W +: PIX_W];
        end else begin : g_top
            assign word_next[gi*PIX_W +: PIX_W] =
                (lane_reg == 2'(gi)) ? i_data : '0;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lane_reg <= '0;
            cnt_reg  <= '0;
            pack_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= o_word_valid && i_word_ready && o_word_last;
            if (accept) begin
                lane_reg <= complete ? 2'd0 : lane_reg + 2'd1;
                pack_reg <= complete ? '0 : word_next[PACK_W-1:0];
                cnt_reg  <= frame_end ? '0 : cnt_reg + CNT_W'(1);
            end
        end
    end

    axis_out_reg u_out_reg (
        .clk        (axi_clk),
        .rst_n      (axi_reset_n),
        .load       (complete),
        .load_data  (word_next),
        .load_keep  (keep_next),
        .load_last  (frame_end),
        .load_ready (o_data_ready),
        .out_valid  (o_word_valid),
        .out_data   (o_word_data),
        .out_keep   (o_word_keep),
        .out_last   (o_word_last),
        .out_ready  (i_word_ready)
    );

    assign o_frame_done = done_reg;

endmodule

// File: tb/tb_conv_out_packer.sv
// Drives three packers (8-, 10- and 1-pixel frames) with shared stimulus and
// checks each against a byte-accumulating reference model.
module tb_conv_out_packer;

    localparam int N_DUT = 3;
    localparam int FP_TAB [N_DUT] = '{8, 10, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr = 1'b0;

    logic        dready [N_DUT];
    logic        wvalid [N_DUT];
    logic [31:0] wdata  [N_DUT];
    logic [3:0]  wkeep  [N_DUT];
    logic        wlast  [N_DUT];
    logic        fdone  [N_DUT];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        conv_out_packer #(
            .FRAME_PIXELS (FP_TAB[gi]),
            .CNT_W        (20)
        ) u_dut (
            .axi_clk      (clk),
            .axi_reset_n  (rst_n),
            .i_data_valid (dv),
            .i_data       (din),
            .o_data_ready (dready[gi]),
            .o_word_valid (wvalid[gi]),
            .o_word_data  (wdata[gi]),
            .o_word_keep  (wkeep[gi]),
            .o_word_last  (wlast[gi]),
            .i_word_ready (wr),
            .o_frame_done (fdone[gi])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected output register and partial-word bytes.
    bit          m_valid [N_DUT];
    logic [31:0] m_data  [N_DUT];
    logic [3:0]  m_keep  [N_DUT];
    bit          m_last  [N_DUT];
    bit          m_done  [N_DUT];
    logic [31:0] m_acc   [N_DUT];
    int          m_n     [N_DUT];
    int          m_cnt   [N_DUT];
    int          m_frames[N_DUT];
    int          done_cnt[N_DUT];
    int          last_hs [N_DUT];

    logic [36:0] hs0 [$];
    logic [36:0] hs1 [$];
    logic [36:0] hs2 [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_DUT; k++) begin
            m_valid[k] = 0; m_data[k] = '0; m_keep[k] = '0; m_last[k] = 0;
            m_done[k] = 0; m_acc[k] = '0; m_n[k] = 0; m_cnt[k] = 0;
            m_frames[k] = 0; done_cnt[k] = 0; last_hs[k] = 0;
        end
        hs0.delete(); hs1.delete(); hs2.delete();
    endtask

    task automatic model_update(input int k, input logic v, input logic [7:0] d, input logic r);
        bit rdy, acc, drain;
        rdy   = !m_valid[k] || r;
        acc   = v && rdy;
        drain = m_valid[k] && r;
        m_done[k] = drain && m_last[k];
        if (m_done[k]) m_frames[k]++;
        if (acc) begin
            m_acc[k] = m_acc[k] | (32'(d) << (8 * m_n[k]));
            m_n[k]++;
            m_cnt[k]++;
            if (m_n[k] == 4 || m_cnt[k] == FP_TAB[k]) begin
                m_data[k]  = m_acc[k];
                m_keep[k]  = 4'((1 << m_n[k]) - 1);
                m_last[k]  = (m_cnt[k] == FP_TAB[k]);
                m_valid[k] = 1;
                if (m_last[k]) m_cnt[k] = 0;
                m_acc[k] = '0;
                m_n[k]   = 0;
            end else if (drain) begin
                m_valid[k] = 0;
            end
        end else if (drain) begin
            m_valid[k] = 0;
        end
    endtask

    task automatic push_hs(input int k, input logic [36:0] w);
        case (k)
            0: hs0.push_back(w);
            1: hs1.push_back(w);
            default: hs2.push_back(w);
        endcase
    endtask

    // One cycle: drive at the falling edge, check outputs, advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic acc0);
        @(negedge clk);
        dv = v; din = d; wr = r;
        #1;
        acc0 = v && (!m_valid[0] || r);
        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("i%0d_ready", k), 64'(dready[k]), 64'(!m_valid[k] || r));
            check_eq($sformatf("i%0d_valid", k), 64'(wvalid[k]), 64'(m_valid[k]));
            if (m_valid[k]) begin
                check_eq($sformatf("i%0d_data", k), 64'(wdata[k]), 64'(m_data[k]));
                check_eq($sformatf("i%0d_keep", k), 64'(wkeep[k]), 64'(m_keep[k]));
                check_eq($sformatf("i%0d_last", k), 64'(wlast[k]), 64'(m_last[k]));
            end
            check_eq($sformatf("i%0d_done", k), 64'(fdone[k]), 64'(m_done[k]));
            if (fdone[k]) done_cnt[k]++;
            if (wvalid[k] && r) begin
                push_hs(k, {wlast[k], wkeep[k], wdata[k]});
                if (wlast[k]) last_hs[k]++;
            end
            model_update(k, v, d, r);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; dv = 1'b0; wr = 1'b0;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("i%0d_rst_valid", k), 64'(wvalid[k]), 64'd0);
            check_eq($sformatf("i%0d_rst_data", k),  64'(wdata[k]),  64'd0);
            check_eq($sformatf("i%0d_rst_keep", k),  64'(wkeep[k]),  64'd0);
            check_eq($sformatf("i%0d_rst_last", k),  64'(wlast[k]),  64'd0);
            check_eq($sformatf("i%0d_rst_done", k),  64'(fdone[k]),  64'd0);
            check_eq($sformatf("i%0d_rst_ready", k), 64'(dready[k]), 64'd1);
        end
        model_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, a);
    endtask

    initial begin
        logic       a;
        logic [7:0] pix;
        model_reset();

        // Eight pixels into an 8-pixel frame: two full words, second is last.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, a);
        idle(3);
        check_eq("t1_words", 64'(hs0.size()), 64'd2);
        if (hs0.size() == 2) begin
            check_eq("t1_w0", 64'(hs0[0]), {27'd0, 1'b0, 4'hF, 32'h04030201});
            check_eq("t1_w1", 64'(hs0[1]), {27'd0, 1'b1, 4'hF, 32'h08070605});
        end
        check_eq("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
        check_eq("t1_fp1_words", 64'(hs2.size()), 64'd8);

        // Ten-pixel frame ends on a two-byte word; next frame restarts at lane 0.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h11 + i), 1'b1, a);
        for (int i = 0; i < 4; i++)  step(1'b1, 8'(8'h21 + i), 1'b1, a);
        idle(3);
        check_eq("t2_words", 64'(hs1.size()), 64'd4);
        if (hs1.size() == 4) begin
            check_eq("t2_w2", 64'(hs1[2]), {27'd0, 1'b1, 4'h3, 32'h00001A19});
            check_eq("t2_w3", 64'(hs1[3]), {27'd0, 1'b0, 4'hF, 32'h24232221});
        end

        // Single-pixel frames.
        do_reset();
        step(1'b1, 8'hAB, 1'b1, a);
        idle(3);
        check_eq("t6_words", 64'(hs2.size()), 64'd1);
        if (hs2.size() == 1)
            check_eq("t6_w0", 64'(hs2[0]), {27'd0, 1'b1, 4'h1, 32'h000000AB});
        check_eq("t6_done_cnt", 64'(done_cnt[2]), 64'd1);

        // Back-pressure: source advances only on accepts of the 8-pixel packer.
        do_reset();
        pix = 8'h01;
        for (int c = 0; c < 40 && pix <= 8'h10; c++) begin
            step(1'b1, pix, (c < 4 || c >= 10) ? 1'b1 : 1'b0, a);
            if (a) pix = pix + 8'h01;
        end
        idle(3);
        check_eq("t3_words", 64'(hs0.size()), 64'd4);
        if (hs0.size() == 4) begin
            check_eq("t3_w0", 64'(hs0[0]), {27'd0, 1'b0, 4'hF, 32'h04030201});
            check_eq("t3_w1", 64'(hs0[1]), {27'd0, 1'b1, 4'hF, 32'h08070605});
            check_eq("t3_w2", 64'(hs0[2]), {27'd0, 1'b0, 4'hF, 32'h0C0B0A09});
            check_eq("t3_w3", 64'(hs0[3]), {27'd0, 1'b1, 4'hF, 32'h100F0E0D});
        end

        // Random data, ready toggling every cycle, then fully random ready.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(1'b1, 8'($urandom), (c % 2 == 0) ? 1'b1 : 1'b0, a);
        end
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), a);
        end
        idle(4);
        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("rnd_i%0d_tlast", k), 64'(last_hs[k]), 64'(m_frames[k]));
            check_eq($sformatf("rnd_i%0d_fdone", k), 64'(done_cnt[k]), 64'(m_frames[k]));
        end

        // Reset after six pixels of a ten-pixel frame, then a clean frame.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, a);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h31 + i), 1'b1, a);
        idle(3);
        check_eq("t5_words", 64'(hs1.size()), 64'd3);
        if (hs1.size() == 3) begin
            check_eq("t5_w0", 64'(hs1[0]), {27'd0, 1'b0, 4'hF, 32'h34333231});
            check_eq("t5_w2", 64'(hs1[2]), {27'd0, 1'b1, 4'h3, 32'h00003A39});
        end
        check_eq("t5_done_cnt", 64'(done_cnt[1]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
